// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Single-outstanding RV32I load/store unit sitting between a core and a
// word-organised data memory with a combinational read port and a
// synchronous write port. Sub-word stores are done as a read-modify-write.
//
// Ports
//   clk           single clock, all state changes on the rising edge
//   rst           asynchronous, active-low reset
//   req_valid     core presents an access this cycle
//   req_ready     unit is idle and will accept a request
//   req_we        1 = store, 0 = load
//   req_funct3    RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr      byte address
//   req_wdata     store data, right-aligned
//   resp_valid    one-cycle pulse completing the accepted request
//   resp_rdata    extended load result (0 for stores and errors), held
//   resp_err      misaligned access or illegal funct3, qualified by resp_valid
//   rw_addr_mem   word address to data memory
//   w_data_mem    word written to data memory (0 when not writing)
//   r_ctrl_mem    memory read enable
//   w_ctrl_mem    memory write enable
//   r_data_mem    combinational read word from data memory
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int register_count = 32,
  parameter int data_length    = 32   // only 32 is supported
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_we,
  input  logic [2:0]                        req_funct3,
  input  logic [31:0]                       req_addr,
  input  logic [31:0]                       req_wdata,
  output logic                              resp_valid,
  output logic [31:0]                       resp_rdata,
  output logic                              resp_err,
  output logic [$clog2(register_count)-1:0] rw_addr_mem,
  output logic [data_length-1:0]            w_data_mem,
  output logic                              r_ctrl_mem,
  output logic                              w_ctrl_mem,
  input  logic [data_length-1:0]            r_data_mem
);

  localparam int AW = $clog2(register_count);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } state_e;

  state_e                 state_q, state_d;
  logic                   accept;
  logic                   req_err;

  // Request fields captured at acceptance; the core may change its inputs
  // freely afterwards.
  logic [2:0]             funct3_q;
  logic [1:0]             off_q;
  logic [AW-1:0]          widx_q;
  logic [31:0]            wdata_q;

  logic [data_length-1:0] merge_q;
  logic [31:0]            rdata_q;
  logic                   err_q;

  logic [31:0]            lane;
  logic [31:0]            load_word;
  logic [data_length-1:0] store_word;

  // Address bits above the word index wrap modulo the memory size.
  logic                   unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:AW+2]};

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  // Misalignment / illegal-encoding check on the live request, used only in
  // the accepting cycle to pick the next state.
  // NOTE: every variable written in an always_comb gets a default first, so
  // no path through the case statements can leave it unassigned and infer a
  // latch.
  always_comb begin
    req_err = 1'b1;
    if (req_we) begin
      case (req_funct3)
        3'd0:    req_err = 1'b0;              // SB
        3'd1:    req_err = req_addr[0];       // SH
        3'd2:    req_err = |req_addr[1:0];    // SW
        default: req_err = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'd0, 3'd4: req_err = 1'b0;           // LB, LBU
        3'd1, 3'd5: req_err = req_addr[0];    // LH, LHU
        3'd2:       req_err = |req_addr[1:0]; // LW
        default:    req_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                 state_d = RESP;
          else if (!req_we)            state_d = LOAD;
          else if (req_funct3 == 3'd2) state_d = WRITE;
          else                         state_d = RMW_RD;
        end
      end
      LOAD:    state_d = RESP;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Select the addressed byte/halfword and extend it.
  always_comb begin
    lane      = r_data_mem >> {off_q, 3'b000};
    load_word = r_data_mem;
    case (funct3_q)
      3'd0:    load_word = {{24{lane[7]}},  lane[7:0]};   // LB
      3'd1:    load_word = {{16{lane[15]}}, lane[15:0]};  // LH
      3'd4:    load_word = {24'd0, lane[7:0]};            // LBU
      3'd5:    load_word = {16'd0, lane[15:0]};           // LHU
      default: load_word = r_data_mem;                    // LW
    endcase
  end

  // Replace one lane of the previously read word; SW bypasses the merge.
  always_comb begin
    store_word = merge_q;
    case (funct3_q)
      3'd0:    store_word[{off_q, 3'b000} +: 8]      = wdata_q[7:0];
      3'd1:    store_word[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: store_word = wdata_q;
    endcase
  end

  // Memory strobes decode from the registered state only, so an async reset
  // drops them immediately and suppresses a pending write.
  assign r_ctrl_mem  = (state_q == LOAD) || (state_q == RMW_RD);
  assign w_ctrl_mem  = (state_q == WRITE);
  assign w_data_mem  = w_ctrl_mem ? store_word : '0;
  assign rw_addr_mem = widx_q;
  assign resp_valid  = (state_q == RESP);
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      off_q    <= '0;
      widx_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        funct3_q <= req_funct3;
        off_q    <= req_addr[1:0];
        widx_q   <= req_addr[AW+1:2];
        wdata_q  <= req_wdata;
      end

      if (state_q == RMW_RD) begin
        merge_q <= r_data_mem;
      end

      // The response registers change only on the edge that enters RESP,
      // so the previous result stays visible while a request is in flight.
      if (accept && req_err) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end else if (state_q == LOAD) begin
        rdata_q <= load_word;
        err_q   <= 1'b0;
      end else if (state_q == WRITE) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Bench for load_store_unit with a behavioural data memory. A reference model
// computes, per accepted request, the error flag, the load result, the
// latency and the new memory image from the RV32I access rules; one monitor
// compares every DUT output against that expectation on every falling edge.
// Directed accesses pin the model with hand-computed values, then randomized
// traffic (including back-to-back requests) follows.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int RC = 32;
  localparam int AW = $clog2(RC);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = '0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          req_ready;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] rw_addr_mem;
  logic [31:0]   w_data_mem;
  logic          r_ctrl_mem;
  logic          w_ctrl_mem;
  logic [31:0]   r_data_mem;

  load_store_unit #(.register_count(RC), .data_length(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .rw_addr_mem (rw_addr_mem),
    .w_data_mem  (w_data_mem),
    .r_ctrl_mem  (r_ctrl_mem),
    .w_ctrl_mem  (w_ctrl_mem),
    .r_data_mem  (r_data_mem)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT, plus a backdoor used while idle/in reset.
  logic [31:0]   mem    [RC];
  logic [31:0]   shadow [RC];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_idx = '0;
  logic [31:0]   poke_data = '0;
  int            cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (w_ctrl_mem)   mem[rw_addr_mem] <= w_data_mem;
    else if (poke_en) mem[poke_idx]    <= poke_data;
  end

  assign r_data_mem = mem[rw_addr_mem];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expectation for the most recently accepted request.
  bit          mon_en    = 1'b0;
  int          acc_cyc   = -1000;
  int          exp_lat   = 1;
  int          exp_idx   = 0;
  bit          exp_err   = 1'b0;
  bit          exp_we    = 1'b0;
  logic [2:0]  exp_f3    = '0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] exp_wword = '0;
  logic [31:0] hold_rdata = '0;
  logic [31:0] last_rdata = '0;
  bit          last_err  = 1'b0;
  int          last_d    = 0;

  // Reference model: access size from funct3, alignment from the byte
  // offset, result by shifting and masking the addressed memory word.
  function automatic void model(input bit we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata);
    int          off, idx, size;
    logic [31:0] word, mask, v;
    off  = int'(addr % 32'd4);
    idx  = int'((addr / 32'd4) % RC);
    word = shadow[idx];
    size = 0;
    if (!we) begin
      case (f3)
        3'd0, 3'd4: size = 1;
        3'd1, 3'd5: size = 2;
        3'd2:       size = 4;
        default:    size = 0;
      endcase
    end else begin
      case (f3)
        3'd0:    size = 1;
        3'd1:    size = 2;
        3'd2:    size = 4;
        default: size = 0;
      endcase
    end
    exp_we    = we;
    exp_f3    = f3;
    exp_idx   = idx;
    exp_rdata = '0;
    exp_wword = '0;
    exp_err   = (size == 0) ? 1'b1 : ((off % size) != 0);
    mask      = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    if (exp_err) begin
      exp_lat = 1;
    end else if (!we) begin
      exp_lat = 2;
      v = (word >> (8 * off)) & mask;
      if ((f3 == 3'd0 || f3 == 3'd1) && v[8 * size - 1]) v = v | ~mask;
      exp_rdata = v;
    end else begin
      exp_lat = (size == 4) ? 2 : 3;
      v = (word & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
      shadow[idx] = v;
      exp_wword   = v;
    end
  endfunction

  // Compare process: every falling edge, every output against the model.
  always @(negedge clk) begin
    int d;
    bit busy, is_resp, er, ew;
    int bad;
    if (mon_en) begin
      d       = cyc - acc_cyc;
      busy    = (d >= 0) && (d < exp_lat);
      is_resp = (d == exp_lat - 1);
      er      = busy && !exp_err && (d == 0) && !(exp_we && exp_f3 == 3'd2);
      ew      = busy && !exp_err && exp_we && (d == exp_lat - 2);
      check("req_ready",  req_ready,  !busy);
      check("resp_valid", resp_valid, is_resp);
      check("r_ctrl_mem", r_ctrl_mem, er);
      check("w_ctrl_mem", w_ctrl_mem, ew);
      check("w_data_mem", w_data_mem, ew ? exp_wword : 32'd0);
      if (er || ew) check("rw_addr_mem", rw_addr_mem, exp_idx[AW-1:0]);
      check("resp_rdata", resp_rdata, is_resp ? exp_rdata : hold_rdata);
      if (is_resp) begin
        check("resp_err", resp_err, exp_err);
        bad = 0;
        for (int i = 0; i < RC; i++) if (mem[i] !== shadow[i]) bad++;
        check("mem_image", bad, 0);
        hold_rdata = exp_rdata;
        last_rdata = resp_rdata;
        last_err   = resp_err;
        last_d     = d;
      end
    end
  end

  task automatic poke(input int idx, input logic [31:0] val);
    poke_idx    = idx[AW-1:0];
    poke_data   = val;
    poke_en     = 1'b1;
    shadow[idx] = val;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Present a request, hold it until the DUT takes it, then scramble the
  // request fields so the DUT must rely on its own registered copy.
  task automatic issue(input bit we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    n = 0;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", req_ready, 1'b1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    model(we, f3, addr, wdata);
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 20);
    check("done_timeout", req_ready, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},   req_ready,   1'b1);
    check({tag, "_resp_valid"},  resp_valid,  1'b0);
    check({tag, "_resp_rdata"},  resp_rdata,  32'd0);
    check({tag, "_resp_err"},    resp_err,    1'b0);
    check({tag, "_r_ctrl"},      r_ctrl_mem,  1'b0);
    check({tag, "_w_ctrl"},      w_ctrl_mem,  1'b0);
    check({tag, "_rw_addr"},     rw_addr_mem, '0);
    check({tag, "_w_data"},      w_data_mem,  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] saved;
    int          a1;
    logic [2:0]  f3;
    bit          we;
    logic [31:0] addr;
    logic [2:0]  ld_ops [5];
    ld_ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    #2 rst = 1'b0;
    for (int i = 0; i < RC; i++) poke(i, $urandom);
    poke(3, 32'h8899_AABB);
    poke(5, 32'h1122_3344);
    check_reset_outputs("reset");

    // Release and issue on the very first edge afterwards.
    @(negedge clk);
    rst        = 1'b1;
    hold_rdata = '0;
    mon_en     = 1'b1;

    issue(1'b0, 3'd0, 32'h0000_000D, 32'h0);           // LB
    check("model_lb", exp_rdata, 32'hFFFF_FFAA);
    wait_done();
    check("lb_rdata", last_rdata, 32'hFFFF_FFAA);
    check("lb_err",   last_err,   1'b0);
    check("lb_lat",   last_d + 1, 2);

    issue(1'b0, 3'd5, 32'h0000_000E, 32'h0);           // LHU
    wait_done();
    check("lhu_rdata", last_rdata, 32'h0000_8899);
    issue(1'b0, 3'd1, 32'h0000_000E, 32'h0);           // LH
    wait_done();
    check("lh_rdata", last_rdata, 32'hFFFF_8899);

    issue(1'b1, 3'd0, 32'h0000_0016, 32'hFFFF_FFEE);   // SB
    check("model_sb", shadow[5], 32'h11EE_3344);
    wait_done();
    check("sb_mem",   mem[5],     32'h11EE_3344);
    check("sb_err",   last_err,   1'b0);
    check("sb_lat",   last_d + 1, 3);

    saved = mem[1];
    issue(1'b1, 3'd2, 32'h0000_0006, 32'h1234_5678);   // misaligned SW
    wait_done();
    check("sw_mis_err",   last_err,   1'b1);
    check("sw_mis_rdata", last_rdata, 32'd0);
    check("sw_mis_lat",   last_d + 1, 1);
    check("sw_mis_mem",   mem[1],     saved);

    // Wrapping SW followed by a request held valid while the unit is busy.
    issue(1'b1, 3'd2, 32'h0000_0080, 32'hCAFE_F00D);
    a1 = acc_cyc;
    issue(1'b0, 3'd2, 32'h0000_0000, 32'h0);
    check("b2b_gap", acc_cyc - a1, 3);
    wait_done();
    check("wrap_mem",   mem[0],     32'hCAFE_F00D);
    check("wrap_rdata", last_rdata, 32'hCAFE_F00D);

    // Reset in the WRITE cycle of an SH: write suppressed, no response.
    saved = mem[2];
    issue(1'b1, 3'd1, 32'h0000_0008, 32'h0000_BEEF);
    @(negedge clk);
    @(negedge clk);
    check("sh_in_write", w_ctrl_mem, 1'b1);
    #1;
    mon_en = 1'b0;
    rst    = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    @(negedge clk);
    check("midreset_mem", mem[2], saved);
    check_reset_outputs("midreset_hold");
    shadow[2]  = saved;
    acc_cyc    = -1000;
    exp_lat    = 1;
    hold_rdata = '0;
    rst        = 1'b1;
    mon_en     = 1'b1;
    issue(1'b0, 3'd2, 32'h0000_0008, 32'h0);
    wait_done();
    check("post_reset_rdata", last_rdata, saved);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 3) == 0)  f3 = 3'($urandom);
      else if (we)                    f3 = 3'($urandom_range(0, 2));
      else                            f3 = ld_ops[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0)  addr = $urandom;
      else                            addr = $urandom_range(0, 4 * RC + 7);
      issue(we, f3, addr, $urandom);
      if ($urandom_range(0, 2) != 0) begin
        wait_done();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    wait_done();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter register_count, default 32, giving the number of 32-bit words in the attached data memory.
REQ-002 SHALL have parameter data_length, default 32, giving the memory word width; only 32 is supported.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  core issues an access this cycle.
REQ-006 req_ready  output  1  unit can accept a request (high only in IDLE).
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RV32I funct3: loads 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores 0 SB, 1 SH, 2 SW.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle pulse completing the accepted request.
REQ-012 resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-013 resp_err  output  1  misaligned or illegal funct3; qualified by resp_valid.
REQ-014 rw_addr_mem  output  $clog2(register_count)  word address to data memory.
REQ-015 w_data_mem  output  data_length  word written to data memory.
REQ-016 r_ctrl_mem  output  1  memory read enable.
REQ-017 w_ctrl_mem  output  1  memory write enable; memory writes at the rising edge while high.
REQ-018 r_data_mem  input  data_length  combinational read word, valid in the same cycle as r_ctrl_mem.

Function
REQ-019 Request SHALL be accepted on a rising edge where req_valid && req_ready; all req_* fields SHALL be registered at acceptance, and later changes SHALL be ignored.
REQ-020 rw_addr_mem SHALL equal registered req_addr[$clog2(register_count)+1:2]; higher address bits SHALL be ignored (modulo wrap).
REQ-021 FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP; r_ctrl_mem, w_ctrl_mem, req_ready and resp_valid SHALL decode from the registered state only.
REQ-022 IDLE + accept: error -> RESP; load -> LOAD; SW -> WRITE; SB/SH -> RMW_RD.
REQ-023 LOAD: r_ctrl_mem=1; at edge, capture the selected byte/halfword (by addr[1:0]), sign-extend (LB/LH) or zero-extend (LBU/LHU) or pass (LW) into resp_rdata; -> RESP.
REQ-024 RMW_RD: r_ctrl_mem=1; at edge, capture r_data_mem into merge register; -> WRITE.
REQ-025 WRITE: w_ctrl_mem=1; w_data_mem = req_wdata (SW) or merge word with byte lane addr[1:0] (SB) / halfword lane addr[1] (SH) replaced by req_wdata low bits; -> RESP.
REQ-026 RESP: resp_valid=1 for exactly one cycle; -> IDLE; no response backpressure.
REQ-027 Error: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; load funct3 3,6,7; store funct3 3..7; errors SHALL NOT assert r_ctrl_mem or w_ctrl_mem.
REQ-028 Latency from acceptance edge to resp_valid cycle: error 1, load 2, SW 2, SB/SH 3 cycles; req_ready returns the cycle after RESP.
REQ-029 r_ctrl_mem and w_ctrl_mem SHALL never be high in the same cycle; outside active states both SHALL be 0 and w_data_mem SHALL be 0.
REQ-030 resp_rdata SHALL hold its value until the next load/store/error response overwrites it.

Reset
REQ-031 rst low SHALL immediately force state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, r_ctrl_mem=0, w_ctrl_mem=0, rw_addr_mem=0, w_data_mem=0.
REQ-032 rst asserted during WRITE before the edge SHALL suppress the write (memory word unchanged); in-flight request SHALL be discarded without a response.
REQ-033 First acceptance SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-034 Memory word 3 = 0x8899AABB; LB addr 0x0D -> resp after 2 cycles, rdata 0xFFFFFFAA, err 0.
REQ-035 Same word; LHU addr 0x0E -> rdata 0x00008899; LH addr 0x0E -> 0xFFFF8899.
REQ-036 Word 5 = 0x11223344; SB addr 0x16 data 0xFFFFFFEE -> RMW_RD then WRITE, word 5 = 0x11EE3344, resp at 3 cycles, err 0.
REQ-037 SW addr 0x06 data 0x12345678 -> resp 1 cycle later with err 1, rdata 0, w_ctrl_mem never high, memory unchanged.
REQ-038 SW addr 0x80 (register_count=32) data 0xCAFEF00D -> writes word 0 (wrap); req_valid held high during busy -> second request accepted only after RESP.
REQ-039 SH addr 0x08 with rst pulsed low during WRITE -> word 2 unchanged, no resp_valid, outputs at reset values.
